// File: rtl/fp_pkg.sv
// Shared floating-point definitions for the sequential multiply/divide paths.
// The constants describe the IEEE-754 binary32 format.
package fp_pkg;

    localparam int K    = 23;
    localparam int E    = 8;
    localparam int BIAS = (1 << (E - 1)) - 1;

    // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB set.
    localparam logic [E+K:0] QNAN = {1'b0, {E{1'b1}}, 1'b1, {(K-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        NORM = 2'd2
    } fp_state_e;

    // Operand-driven special result classes, resolved before NORM.
    typedef enum logic [1:0] {
        SPC_NONE = 2'd0,
        SPC_NAN  = 2'd1,
        SPC_INF  = 2'd2,
        SPC_ZERO = 2'd3
    } fp_spc_e;

endpackage

// File: rtl/seq_mant_mul.sv
// Radix-2 shift-add unsigned multiplier: N steps, one bit of multiplier
// per cycle. done is high during the cycle of the final step, so the
// product register holds the full result right after that edge.
module seq_mant_mul #(
    parameter int N = 24
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   mcand,
    input  logic [N-1:0]   mplier,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int CW = $clog2(N + 1);

    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*N-1:0] mcand_q, mcand_d;
    logic [N-1:0]   mplier_q, mplier_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic           busy_q, busy_d;

    // Load operands on start, then shift-add one multiplier bit per cycle.
    always_comb begin
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        busy_d   = busy_q;
        if (busy_q) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end else begin
                acc_d = acc_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
            busy_d   = (cnt_q != CW'(1));
        end else if (start) begin
            mcand_d  = {{N{1'b0}}, mcand};
            mplier_d = mplier;
            acc_d    = {(2*N){1'b0}};
            cnt_d    = CW'(N);
            busy_d   = 1'b1;
        end else begin
            busy_d   = 1'b0;
        end
    end

    // Iteration state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= {CW{1'b0}};
            mcand_q  <= {(2*N){1'b0}};
            mplier_q <= {N{1'b0}};
            acc_q    <= {(2*N){1'b0}};
            busy_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            busy_q   <= busy_d;
        end
    end

    assign busy    = busy_q;
    assign done    = busy_q && (cnt_q == CW'(1));
    assign product = acc_q;

endmodule

// File: rtl/fp_multiply.sv
// Sequential IEEE-754 multiplier, round toward zero, flush-to-zero.
// Fixed latency regardless of operands: specials still run the datapath.
module fp_multiply
    import fp_pkg::*;
#(
    parameter int K = fp_pkg::K,
    parameter int E = fp_pkg::E
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [E+K:0] a,
    input  logic [E+K:0] b,
    output logic         ready,
    output logic         done,
    output logic [E+K:0] result
);

    localparam int          N         = K + 1;
    localparam logic [E+1:0] BIAS_X    = (E+2)'(BIAS);
    localparam logic [E+1:0] EXP_MAX_X = {2'b00, {E{1'b1}}};

    fp_state_e     state_q, state_d;
    fp_spc_e       spc_q, spc_d, spc_s;
    logic [E+K:0]  a_q, a_d, b_q, b_d;
    logic [E+K:0]  result_q, result_d, norm_s;
    logic          done_q, done_d, ready_q, ready_d;

    logic           mul_start_s, mul_busy_s, mul_done_s;
    logic [2*N-1:0] prod_s;

    logic                sign_s;
    logic [E-1:0]        ea_s, eb_s;
    logic                a_nan_s, b_nan_s, a_inf_s, b_inf_s, a_zero_s, b_zero_s;
    logic signed [E+1:0] exp_s;
    logic [K-1:0]        frac_s;
    logic                unused_s;

    assign mul_start_s = (state_q == IDLE) && start;

    seq_mant_mul #(.N(N)) u_mant_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start_s),
        .mcand   ({|a[E+K-1:K], a[K-1:0]}),
        .mplier  ({|b[E+K-1:K], b[K-1:0]}),
        .busy    (mul_busy_s),
        .done    (mul_done_s),
        .product (prod_s)
    );

    assign sign_s   = a_q[E+K] ^ b_q[E+K];
    assign ea_s     = a_q[E+K-1:K];
    assign eb_s     = b_q[E+K-1:K];
    assign a_nan_s  = (&ea_s) && (|a_q[K-1:0]);
    assign b_nan_s  = (&eb_s) && (|b_q[K-1:0]);
    assign a_inf_s  = (&ea_s) && !(|a_q[K-1:0]);
    assign b_inf_s  = (&eb_s) && !(|b_q[K-1:0]);
    assign a_zero_s = ~|ea_s;
    assign b_zero_s = ~|eb_s;
    assign unused_s = ^{prod_s[K-1:0], mul_busy_s};

    // Classify the captured operands; subnormals count as zero.
    always_comb begin
        spc_s = SPC_NONE;
        if (a_nan_s || b_nan_s || (a_inf_s && b_zero_s) || (b_inf_s && a_zero_s)) begin
            spc_s = SPC_NAN;
        end else if (a_inf_s || b_inf_s) begin
            spc_s = SPC_INF;
        end else if (a_zero_s || b_zero_s) begin
            spc_s = SPC_ZERO;
        end else begin
            spc_s = SPC_NONE;
        end
    end

    // Normalise the finished product, truncate, and clamp the exponent.
    always_comb begin
        exp_s = $signed({2'b00, ea_s}) + $signed({2'b00, eb_s}) - $signed(BIAS_X)
              + $signed({{(E+1){1'b0}}, prod_s[2*K+1]});
        if (prod_s[2*K+1]) begin
            frac_s = prod_s[2*K:K+1];
        end else begin
            frac_s = prod_s[2*K-1:K];
        end
        if (exp_s >= $signed(EXP_MAX_X)) begin
            norm_s = {sign_s, {E{1'b1}}, {K{1'b0}}};
        end else if (exp_s <= $signed({(E+2){1'b0}})) begin
            norm_s = {sign_s, {(E+K){1'b0}}};
        end else begin
            norm_s = {sign_s, exp_s[E-1:0], frac_s};
        end
    end

    // Control FSM: accept in IDLE, iterate in MUL, publish in NORM.
    always_comb begin
        state_d  = state_q;
        spc_d    = spc_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    state_d = MUL;
                end else begin
                    state_d = IDLE;
                end
            end
            MUL: begin
                spc_d = spc_s;
                if (mul_done_s) begin
                    state_d = NORM;
                end else begin
                    state_d = MUL;
                end
            end
            NORM: begin
                case (spc_q)
                    SPC_NAN:  result_d = QNAN;
                    SPC_INF:  result_d = {sign_s, {E{1'b1}}, {K{1'b0}}};
                    SPC_ZERO: result_d = {sign_s, {(E+K){1'b0}}};
                    default:  result_d = norm_s;
                endcase
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ready_d = (state_d == IDLE);
    end

    // Control and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            spc_q    <= SPC_NONE;
            a_q      <= {(E+K+1){1'b0}};
            b_q      <= {(E+K+1){1'b0}};
            result_q <= {(E+K+1){1'b0}};
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            spc_q    <= spc_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
        end
    end

    assign ready  = ready_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_fp_multiply.sv
// Scoreboard bench for fp_multiply (binary32): directed vectors, random
// normal operands against a truncating reference, busy-start and reset abort.
module tb_fp_multiply;

    localparam int LAT = 26;

    logic        clk = 1'b0;
    logic        rst_n, start;
    logic [31:0] a, b;
    logic        ready, done;
    logic [31:0] result;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    fp_multiply #(.K(23), .E(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .ready  (ready),
        .done   (done),
        .result (result)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Truncating binary32 reference built on a full-width multiply.
    function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
        logic        s, xn, yn, xi, yi, xz, yz;
        logic [47:0] p;
        logic [22:0] f;
        int          e;
        s  = x[31] ^ y[31];
        xn = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
        yn = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
        xi = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
        yi = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);
        xz = (x[30:23] == 8'h00);
        yz = (y[30:23] == 8'h00);
        if (xn || yn || (xi && yz) || (yi && xz)) return 32'h7FC00000;
        if (xi || yi) return {s, 8'hFF, 23'd0};
        if (xz || yz) return {s, 31'd0};
        p = {1'b1, x[22:0]} * {1'b1, y[22:0]};
        e = int'(x[30:23]) + int'(y[30:23]) - 127;
        if (p[47]) begin
            e = e + 1;
            f = p[46:24];
        end else begin
            f = p[45:23];
        end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return {s, 31'd0};
        return {s, e[7:0], f};
    endfunction

    task automatic issue(input string tag, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] exp);
        chk({tag, "_rdy"}, {31'd0, ready}, 32'd1);
        a     = x;
        b     = y;
        start = 1'b1;
        sb.push_back(exp);
    endtask

    // Wait for done counting edges from the accepting edge; optionally
    // hammer start with fresh operands while the operation is busy.
    task automatic wait_done(input string tag, input bit poke);
        int          cyc;
        int          nd;
        bit          seen;
        logic [31:0] exp;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 100) begin
            @(posedge clk);
            cyc++;
            #1;
            if (poke && cyc >= 3 && cyc <= 8) begin
                a     = $urandom;
                b     = $urandom;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (poke && cyc == 5) chk({tag, "_busy_rdy"}, {31'd0, ready}, 32'd0);
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        chk({tag, "_lat"}, 32'(cyc), 32'(LAT));
        if (sb.size() > 0) begin
            exp = sb.pop_front();
            chk(tag, result, exp);
        end else begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end
        if (poke) begin
            nd = 0;
            repeat (30) begin
                @(posedge clk);
                #1;
                if (done) nd++;
            end
            chk({tag, "_extra_done"}, 32'(nd), 32'd0);
            chk({tag, "_held"}, result, exp);
        end
    endtask

    initial begin
        logic [31:0] va[6];
        logic [31:0] vb[6];
        logic [31:0] ve[6];
        logic [31:0] rx, ry;
        int          nd;

        va = '{32'h3FC00000, 32'hC0000000, 32'h3FFFFFFF, 32'h7F7FFFFF, 32'h00800000, 32'h7F800000};
        vb = '{32'h40000000, 32'h40400000, 32'h3FFFFFFF, 32'h40000000, 32'h00800000, 32'h00000000};
        ve = '{32'h40400000, 32'hC0C00000, 32'h407FFFFE, 32'h7F800000, 32'h00000000, 32'h7FC00000};

        rst_n = 1'b0;
        start = 1'b0;
        a     = 32'd0;
        b     = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors, issued back to back in the cycle after done.
        for (int i = 0; i < 6; i++) begin
            issue($sformatf("dir%0d", i), va[i], vb[i], ve[i]);
            wait_done($sformatf("dir%0d", i), 1'b0);
        end
        issue("neginf", 32'hFF800000, 32'h40000000, 32'hFF800000);
        wait_done("neginf", 1'b0);

        // Random normal operands with mid-range exponents.
        for (int i = 0; i < 6; i++) begin
            rx = $urandom;
            ry = $urandom;
            rx[30:23] = 8'($urandom_range(100, 150));
            ry[30:23] = 8'($urandom_range(100, 150));
            issue($sformatf("rnd%0d", i), rx, ry, ref_mul(rx, ry));
            wait_done($sformatf("rnd%0d", i), 1'b0);
        end

        // Start pulses with new operands while busy are ignored.
        issue("ign", 32'h3FC00000, 32'h40000000, 32'h40400000);
        wait_done("ign", 1'b1);

        // Reset in the middle of MUL aborts the operation.
        issue("abort", 32'hC0000000, 32'h40400000, 32'hC0C00000);
        repeat (10) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk("abort_ready", {31'd0, ready}, 32'd1);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_result", result, 32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) nd++;
        end
        chk("abort_no_done", 32'(nd), 32'd0);
        issue("post_rst", 32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE);
        wait_done("post_rst", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp_multiply.md
FP_MULTIPLY -- requirements
Module: fp_multiply

Interface
REQ-001 SHALL have parameter K, default 23, the fraction width; the significand is K+1 bits.
REQ-002 SHALL have parameter E, default 8, the exponent width; the bias is 2^(E-1)-1.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit, a request to multiply; it is sampled only while ready=1.
REQ-006 SHALL have ports a and b, input, E+K+1 bits each, IEEE-754 operands; they are captured on the accepting edge.
REQ-007 SHALL have port ready, output, 1 bit, high only in IDLE.
REQ-008 SHALL have port done, output, 1 bit, a single-cycle pulse that marks result valid.
REQ-009 SHALL have port result, output, E+K+1 bits, the product; it is held until the next done.

Function
REQ-010 SHALL run a state machine IDLE -> MUL -> NORM -> IDLE; start=1 in IDLE captures a and b and enters MUL.
REQ-011 SHALL stay in MUL exactly K+1 cycles, doing one radix-2 shift-add step per cycle on the (K+1)x(K+1) significands into a 2(K+1)-bit product.
REQ-012 SHALL spend one cycle in NORM, which registers result, drives done=1 and returns to IDLE.
REQ-013 SHALL make latency fixed at K+3 rising edges from the accepting edge to done high (26 for K=23), special operands included.
REQ-014 SHALL ignore start while busy; operand changes during MUL/NORM have no effect.
REQ-015 SHALL accept start=1 in the IDLE cycle right after done, giving back-to-back throughput of one operation per K+3 cycles.
REQ-016 SHALL compute the sign as sign(a) XOR sign(b) for every result except NaN.
REQ-017 SHALL compute the exponent in an E+2-bit signed intermediate as ea+eb-bias, plus 1 when product bit 2K+1 is set.
REQ-018 SHALL normalise the fraction: if product bit 2K+1=1, fraction = p[2K:K+1]; else fraction = p[2K-1:K].
REQ-019 SHALL round toward zero by truncating the discarded product bits.
REQ-020 SHALL handle overflow: final exponent >= 2^E-1 gives signed infinity.
REQ-021 SHALL handle underflow: final exponent <= 0 gives signed zero (flush-to-zero).
REQ-022 SHALL treat subnormal inputs (exponent 0) as signed zero.
REQ-023 SHALL give a NaN operand, or inf times zero, the canonical quiet NaN 0x7FC00000 (sign 0).
REQ-024 SHALL give inf times a finite nonzero operand signed infinity, and zero times a finite operand signed zero.
REQ-025 SHALL decide special cases from the captured operands in the cycle after acceptance; the MUL datapath still runs, and NORM selects the special value.

Reset
REQ-026 SHALL, on rst_n=0 and at any time including mid-MUL/NORM, immediately force state=IDLE, ready=1, done=0, result=0 and clear the product and counter registers.
REQ-027 SHALL NOT produce done for an operation aborted by reset; the first start after rst_n rises is handled normally.

Structure
REQ-028 SHALL take K, E, BIAS, the QNAN constant and the state enum (IDLE, MUL, NORM) from shared package fp_pkg, which the divider path also uses.
REQ-029 SHALL place the shift-add iteration (counter, multiplicand, accumulator) in one sub-module, seq_mant_mul, with start/busy/done; unpack, specials and normalisation stay in fp_multiply.

Verification
REQ-030 SHALL cover: a=0x3FC00000, b=0x40000000, start -> done exactly 26 cycles later, result=0x40400000.
REQ-031 SHALL cover: a=0xC0000000, b=0x40400000 -> 0xC0C00000; a=0x3FFFFFFF, b=0x3FFFFFFF -> 0x407FFFFE (truncation).
REQ-032 SHALL cover: a=0x7F7FFFFF, b=0x40000000 -> 0x7F800000; a=0x00800000, b=0x00800000 -> 0x00000000.
REQ-033 SHALL cover: a=0x7F800000, b=0x00000000 -> 0x7FC00000; a=0xFF800000, b=0x40000000 -> 0xFF800000; each with 26-cycle latency.
REQ-034 SHALL cover: start pulses during MUL with new operands -> ignored, first result unchanged, ready low until done.
REQ-035 SHALL cover: rst_n low at cycle 10 of MUL -> ready=1, result=0, no done; the next start gives the correct result.
